br_arb: RTL
===========

BR_ARB -- requirements
Module: br_arb

Interface
REQ-001 Parameter RR_EN, default 1, arbitration mode: 1 = round-robin, 0 = fixed priority with port 0 highest.
REQ-002 i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_req_valid  input  2  per-port request valid; [0] = branch unit, [1] = SLT/SLTU path.
REQ-005 o_req_ready  output  2  per-port request accepted this cycle.
REQ-006 i_rs1_p0, i_rs2_p0, i_rs1_p1, i_rs2_p1  input  32 each  operands, one pair per port.
REQ-007 i_op_p0, i_op_p1  input  3 each  funct3 per port.
REQ-008 o_resp_valid  output  1  result held and valid.
REQ-009 i_resp_ready  input  1  consumer accepts result.
REQ-010 o_resp_id  output  1  index of the port that produced the result.
REQ-011 o_resp_result  output  1  branch taken, or SLT/SLTU bit.
REQ-012 o_resp_err  output  1  funct3 not legal for the granted port.

Function
REQ-013 The block SHALL contain one brc comparator instance, shared by both ports.
- Operand mux driven by the current grant.
REQ-014 brc polarity SHALL be br_un = 1 for signed compare and 0 for unsigned.
- op 100, 101, 010: br_un = 1.
- op 110, 111, 011: br_un = 0.
- op 000, 001, invalid: don't-care.
REQ-015 Port 0 result mapping SHALL be:
- 000 BEQ = equal
- 001 BNE = !equal
- 100/110 = less
- 101/111 = !less
- 010, 011: illegal
REQ-016 Port 1 result mapping SHALL be: 010 SLT = less, 011 SLTU = less; all other ops illegal.
REQ-017 An illegal op SHALL still be accepted, returning result 0 with o_resp_err = 1.
REQ-018 The FSM SHALL have two states, IDLE and HOLD.
- IDLE -> HOLD on any accept.
- HOLD -> IDLE when i_resp_ready = 1 and no new accept in that cycle.
- HOLD -> HOLD when i_resp_ready = 1 and a new accept occurs in the same cycle.
REQ-019 A port may be granted only when the pipeline can take it: grant_ok = (state == IDLE) or (state == HOLD and i_resp_ready = 1).
REQ-020 At most one bit of o_req_ready SHALL be high per cycle.
- That bit is asserted only for a valid port and only when grant_ok holds.
- o_req_ready is combinational from valid, state and pointer.
REQ-021 When both ports are valid and RR_EN = 1, the grant SHALL go to the port not granted last.
- The last-grant pointer updates only on an accept.
- When RR_EN = 0, port 0 always wins.
REQ-022 When only one port is valid, it SHALL be granted regardless of the pointer.
REQ-023 Latency SHALL be one cycle: an accept at edge N makes o_resp_valid, o_resp_id, o_resp_result and o_resp_err valid after edge N.
- Compare result is registered, not recomputed later.
REQ-024 While o_resp_valid = 1 and i_resp_ready = 0, all response outputs SHALL hold stable and o_req_ready SHALL be 00.
REQ-025 Back-to-back operation at one result per cycle SHALL be sustained while i_resp_ready stays high.
REQ-026 Request inputs SHALL be sampled only in the accept cycle.
- Operand changes after acceptance do not affect the held result.

Reset
REQ-027 On i_rst_n = 0 (async assert, any state), the block SHALL force:
- state = IDLE
- o_resp_valid = 0, o_resp_id = 0, o_resp_result = 0, o_resp_err = 0
- pointer = 1, so port 0 wins the first tie
REQ-028 o_req_ready SHALL be 00 while reset is asserted.
REQ-029 A result held when reset asserts SHALL be discarded.
REQ-030 The first accept SHALL be possible in the first cycle after release.

Verification
REQ-031 Signed vs unsigned compare:
- Stimulus: p0 op=100 (BLT), rs1=0xFFFFFFFF, rs2=0x00000001, resp_ready=1.
- Required: next cycle o_resp_valid=1, o_resp_result=1, o_resp_id=0.
- Repeat with op=110 (BLTU): o_resp_result=0.
REQ-032 Round-robin tie:
- Stimulus: both ports valid for 4 cycles; p1 op=010, rs1=-5, rs2=3; resp_ready=1.
- Required: grants alternate 0,1,0,1; p1 results = 1.
- With RR_EN=0: four grants to p0.
REQ-033 Backpressure:
- Stimulus: accept p0 BEQ with rs1=rs2=0x1234, then hold resp_ready=0 for 3 cycles.
- Required: result=1 stable throughout; o_req_ready=00 throughout.
- Required: at the resp_ready=1 cycle, a pending p1 request is accepted the same cycle.
REQ-034 Illegal op:
- Stimulus: p1 op=000.
- Required: o_resp_err=1, o_resp_result=0, o_resp_id=1.
REQ-035 Reset mid-operation:
- Stimulus: assert i_rst_n=0 asynchronously while in HOLD.
- Required: o_resp_valid=0 immediately, without a clock edge.
- Required: after release, a simultaneous p0/p1 request grants p0.
REQ-036 Boundary compares:
- 0x80000000 vs 0x7FFFFFFF: BLT taken, BLTU not taken.
- Equal operands: BGE=1, BGEU=1, BNE=0.

Source files
------------

// File: rtl/br_arb.sv
// Two-port arbiter sharing a single branch/set-less-than comparator.
// Port 0 is the branch unit and port 1 is the SLT/SLTU path. Results are registered one cycle after accept.

module brc (
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        br_un,
  output logic        br_eq,
  output logic        br_lt
);

  // Compare the operands: br_un = 1 selects a signed compare, 0 an unsigned one.
  always_comb begin
    br_eq = (rs1 == rs2);
    if (br_un) begin
      br_lt = ($signed(rs1) < $signed(rs2));
    end else begin
      br_lt = (rs1 < rs2);
    end
  end

endmodule

module br_arb #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [1:0]  i_req_valid,
  output logic [1:0]  o_req_ready,
  input  logic [31:0] i_rs1_p0,
  input  logic [31:0] i_rs2_p0,
  input  logic [31:0] i_rs1_p1,
  input  logic [31:0] i_rs2_p1,
  input  logic [2:0]  i_op_p0,
  input  logic [2:0]  i_op_p1,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic        o_resp_id,
  output logic        o_resp_result,
  output logic        o_resp_err
);

  typedef enum logic [0:0] {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t      state_r;
  logic        ptr_r;
  logic        resp_valid_r;
  logic        resp_id_r;
  logic        resp_result_r;
  logic        resp_err_r;

  logic        grant_ok_s;
  logic [1:0]  grant_s;
  logic        gnt_id_s;
  logic        accept_s;
  logic [31:0] rs1_s;
  logic [31:0] rs2_s;
  logic [2:0]  op_s;
  logic        br_un_s;
  logic        br_eq_s;
  logic        br_lt_s;
  logic [1:0]  err_res_s;

  // Signed compares are the BLT/BGE/SLT encodings; all other ops use unsigned.
  function automatic logic op_br_un(input logic [2:0] op);
    logic un;
    case (op)
      3'b100, 3'b101, 3'b010: un = 1'b1;
      default:                un = 1'b0;
    endcase
    return un;
  endfunction

  // Returns {err, result}; an op not legal for the port yields result 0.
  function automatic logic [1:0] op_result(input logic port, input logic [2:0] op,
                                           input logic eq, input logic lt);
    logic [1:0] r;
    if (port == 1'b0) begin
      case (op)
        3'b000:         r = {1'b0, eq};
        3'b001:         r = {1'b0, ~eq};
        3'b100, 3'b110: r = {1'b0, lt};
        3'b101, 3'b111: r = {1'b0, ~lt};
        default:        r = 2'b10;
      endcase
    end else begin
      case (op)
        3'b010, 3'b011: r = {1'b0, lt};
        default:        r = 2'b10;
      endcase
    end
    return r;
  endfunction

  assign grant_ok_s = (state_r == IDLE) || (i_resp_ready == 1'b1);

  // Grant selection; a tie goes to the port not granted last when round-robin is enabled.
  always_comb begin
    grant_s = 2'b00;
    if (!i_rst_n || !grant_ok_s) begin
      grant_s = 2'b00;
    end else begin
      case (i_req_valid)
        2'b01:   grant_s = 2'b01;
        2'b10:   grant_s = 2'b10;
        2'b11: begin
          if (RR_EN && (ptr_r == 1'b0)) begin
            grant_s = 2'b10;
          end else begin
            grant_s = 2'b01;
          end
        end
        default: grant_s = 2'b00;
      endcase
    end
  end

  assign accept_s    = |grant_s;
  assign gnt_id_s    = grant_s[1];
  assign o_req_ready = grant_s;

  // Operand mux feeding the shared comparator.
  always_comb begin
    if (gnt_id_s) begin
      rs1_s = i_rs1_p1;
      rs2_s = i_rs2_p1;
      op_s  = i_op_p1;
    end else begin
      rs1_s = i_rs1_p0;
      rs2_s = i_rs2_p0;
      op_s  = i_op_p0;
    end
  end

  assign br_un_s = op_br_un(op_s);

  brc u_brc (
    .rs1   (rs1_s),
    .rs2   (rs2_s),
    .br_un (br_un_s),
    .br_eq (br_eq_s),
    .br_lt (br_lt_s)
  );

  assign err_res_s = op_result(gnt_id_s, op_s, br_eq_s, br_lt_s);

  // IDLE/HOLD control with the response registers and the last-grant pointer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r       <= IDLE;
      ptr_r         <= 1'b1;
      resp_valid_r  <= 1'b0;
      resp_id_r     <= 1'b0;
      resp_result_r <= 1'b0;
      resp_err_r    <= 1'b0;
    end else if (accept_s) begin
      state_r       <= HOLD;
      ptr_r         <= gnt_id_s;
      resp_valid_r  <= 1'b1;
      resp_id_r     <= gnt_id_s;
      resp_result_r <= err_res_s[0];
      resp_err_r    <= err_res_s[1];
    end else begin
      case (state_r)
        HOLD: begin
          if (i_resp_ready) begin
            state_r      <= IDLE;
            resp_valid_r <= 1'b0;
          end else begin
            state_r      <= HOLD;
            resp_valid_r <= 1'b1;
          end
        end
        IDLE: begin
          state_r      <= IDLE;
          resp_valid_r <= 1'b0;
        end
        default: begin
          state_r      <= IDLE;
          resp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign o_resp_valid  = resp_valid_r;
  assign o_resp_id     = resp_id_r;
  assign o_resp_result = resp_result_r;
  assign o_resp_err    = resp_err_r;

endmodule
